pwm_fade_sequencer: RTL and testbench

CSR bus master that drives the PWM peripheral's CSR port. It ramps one channel's duty register from its current value to a target value in fixed increments, one write per programmable interval. A simple valid/ready command port accepts work from the host or a script engine. The sequencer is the sole writer of the duty registers (0x10–0x1C) while it is busy.

---
 rtl/pwm_fade_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pwm_fade_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_sequencer.sv
// CSR bus master that ramps one PWM duty register from its current value to a
// target in fixed steps, issuing one write per programmable interval.
module pwm_fade_sequencer #(
    parameter int NUM_CHANNELS   = 4,
    parameter int COUNTER_WIDTH  = 16,
    parameter int INTERVAL_WIDTH = 16,
    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [CHAN_W-1:0]         cmd_chan_i,
    input  logic [COUNTER_WIDTH-1:0]  cmd_target_i,
    input  logic [COUNTER_WIDTH-1:0]  cmd_step_i,
    input  logic [INTERVAL_WIDTH-1:0] cmd_interval_i,
    input  logic                      abort_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [7:0]                csr_addr_o,
    output logic                      csr_we_o,
    output logic [31:0]               csr_wdata_o,
    input  logic [31:0]               csr_rdata_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [7:0]                DUTY_BASE = 8'h10;
    localparam logic [INTERVAL_WIDTH-1:0] CNT_ONE   = INTERVAL_WIDTH'(1);

    logic [1:0]                state_q, state_d;
    logic [CHAN_W-1:0]         chan_q, chan_d;
    logic [COUNTER_WIDTH-1:0]  target_q, target_d;
    logic [COUNTER_WIDTH-1:0]  step_q, step_d;
    logic [COUNTER_WIDTH-1:0]  cur_q, cur_d;
    logic [INTERVAL_WIDTH-1:0] interval_q, interval_d;
    logic [INTERVAL_WIDTH-1:0] cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic [COUNTER_WIDTH:0]    sum_ext;
    logic [COUNTER_WIDTH-1:0]  next_val;
    logic [7:0]                duty_addr;
    logic                      chan_legal;

    assign chan_legal  = 32'(cmd_chan_i) < 32'(NUM_CHANNELS);
    assign duty_addr   = DUTY_BASE + (8'(chan_q) << 2);
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

    // The sum carries one extra bit and the subtraction is guarded, so the
    // ramp saturates at the target instead of wrapping.
    always_comb begin
        sum_ext  = {1'b0, cur_q} + {1'b0, step_q};
        next_val = target_q;
        if (step_q != '0 && cur_q != target_q) begin
            if (cur_q < target_q) begin
                if (sum_ext < {1'b0, target_q}) begin
                    next_val = sum_ext[COUNTER_WIDTH-1:0];
                end
            end else if (step_q <= cur_q && (cur_q - step_q) > target_q) begin
                next_val = cur_q - step_q;
            end
        end
    end

    always_comb begin
        csr_addr_o  = '0;
        csr_we_o    = 1'b0;
        csr_wdata_o = '0;
        case (state_q)
            LOAD: begin
                csr_addr_o = duty_addr;
            end
            WRITE: begin
                csr_addr_o  = duty_addr;
                csr_we_o    = ~abort_i;
                csr_wdata_o = 32'(next_val);
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        target_d   = target_q;
        step_d     = step_q;
        interval_d = interval_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    chan_d     = cmd_chan_i;
                    target_d   = cmd_target_i;
                    step_d     = cmd_step_i;
                    interval_d = cmd_interval_i;
                    if (chan_legal) begin
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    cur_d   = csr_rdata_i[COUNTER_WIDTH-1:0];
                    cnt_d   = interval_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WRITE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    cur_d = next_val;
                    if (next_val == target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = interval_q;
                        state_d = WAIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            chan_q     <= '0;
            target_q   <= '0;
            step_q     <= '0;
            interval_q <= '0;
            cur_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            target_q   <= target_d;
            step_q     <= step_d;
            interval_q <= interval_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Only the duty-width slice of the read data is meaningful.
    generate
        if (COUNTER_WIDTH < 32) begin : g_unused_rdata
            logic unused_rdata_hi;
            assign unused_rdata_hi = ^csr_rdata_i[31:COUNTER_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: a PWM register-file model on the CSR port and a
// ramp reference model that predicts every write, done and err pulse.
module tb_pwm_fade_sequencer;

    localparam int NCH = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_chan_i;
    logic [15:0] cmd_target_i;
    logic [15:0] cmd_step_i;
    logic [15:0] cmd_interval_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [7:0]  csr_addr_o;
    logic        csr_we_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_rdata_i;

    pwm_fade_sequencer #(
        .NUM_CHANNELS  (NCH),
        .COUNTER_WIDTH (16),
        .INTERVAL_WIDTH(16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_chan_i    (cmd_chan_i),
        .cmd_target_i  (cmd_target_i),
        .cmd_step_i    (cmd_step_i),
        .cmd_interval_i(cmd_interval_i),
        .abort_i       (abort_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .csr_addr_o    (csr_addr_o),
        .csr_we_o      (csr_we_o),
        .csr_wdata_o   (csr_wdata_o),
        .csr_rdata_i   (csr_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int          cyc = 0;
    logic [15:0] pwm_duty [4];
    logic        preload_en;
    logic [1:0]  preload_idx;
    logic [15:0] preload_val;
    int          ref_duty [4];

    // The PWM peripheral is not reset with the sequencer, so it keeps its registers.
    always_comb begin
        csr_rdata_i = '0;
        if (csr_addr_o >= 8'h10 && csr_addr_o <= 8'h1C && csr_addr_o[1:0] == 2'b00) begin
            csr_rdata_i = {16'h0, pwm_duty[csr_addr_o[3:2]]};
        end
    end

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (preload_en) begin
            pwm_duty[preload_idx] <= preload_val;
        end else if (csr_we_o) begin
            pwm_duty[csr_addr_o[3:2]] <= csr_wdata_o[15:0];
        end
    end

    int          wr_cyc [$];
    logic [7:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          done_cyc [$];
    int          err_cyc [$];
    bit          busy_seen;

    always @(negedge clk_i) begin
        if (csr_we_o === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(csr_addr_o);
            wr_data.push_back(csr_wdata_o);
        end
        if (done_o === 1'b1) done_cyc.push_back(cyc);
        if (err_o === 1'b1) err_cyc.push_back(cyc);
        if (busy_o === 1'b1) busy_seen = 1'b1;
    end

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [1:0] idx, input logic [15:0] val);
        preload_en  = 1'b1;
        preload_idx = idx;
        preload_val = val;
        @(posedge clk_i); #1;
        preload_en  = 1'b0;
        ref_duty[idx] = int'(val);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, cmd_ready_o, 1);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_we"}, csr_we_o, 0);
        checkOutput({tag, "_addr"}, csr_addr_o, 0);
        checkOutput({tag, "_wdata"}, csr_wdata_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_err"}, err_o, 0);
    endtask

    // Issues one command; abort_off / reset_off are cycle offsets from the
    // handshake cycle (-1 = none). Entered and left at posedge+1.
    task automatic applyStimulus(input logic [1:0] chan, input logic [15:0] target,
                                 input logic [15:0] step, input logic [15:0] interval,
                                 input int abort_off, input int reset_off);
        int  exp_val [$];
        int  exp_c [$];
        int  t, cur, tgt, stp, iv, stop, end_c, n_keep, last_c, wait_n;
        bit  legal, done_exp;

        wait_n = 0;
        while (cmd_ready_o !== 1'b1 && wait_n < 100) begin
            @(posedge clk_i); #1;
            wait_n++;
        end
        if (cmd_ready_o !== 1'b1) checkOutput("ready_timeout", cmd_ready_o, 1);

        legal = (int'(chan) < NCH);
        tgt   = int'(target);
        stp   = int'(step);
        iv    = int'(interval);
        cur   = ref_duty[chan];

        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        done_cyc.delete(); err_cyc.delete();
        busy_seen = 1'b0;

        t = cyc;
        if (legal) begin
            do begin
                if (stp == 0 || cur == tgt) cur = tgt;
                else if (cur < tgt) cur = (cur + stp > tgt) ? tgt : cur + stp;
                else cur = (cur - stp < tgt) ? tgt : cur - stp;
                exp_c.push_back(t + 3 + iv + exp_val.size() * (iv + 2));
                exp_val.push_back(cur);
            end while (cur != tgt);
        end

        stop = (abort_off >= 0) ? t + abort_off : ((reset_off >= 0) ? t + reset_off : 32'h3fff_ffff);
        n_keep = 0;
        foreach (exp_c[i]) if (exp_c[i] < stop) n_keep++;
        last_c = legal ? exp_c[exp_c.size() - 1] : t;
        done_exp = legal && (n_keep == exp_c.size()) &&
                   ((reset_off >= 0) ? (last_c + 1 < stop) : (last_c + 1 <= stop));
        end_c = legal ? (((last_c < stop) ? last_c : stop) + 4) : t + 4;
        if (reset_off >= 0) end_c = stop + 8;

        cmd_valid_i    = 1'b1;
        cmd_chan_i     = chan;
        cmd_target_i   = target;
        cmd_step_i     = step;
        cmd_interval_i = interval;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;

        while (cyc < end_c) begin
            abort_i = (abort_off >= 0 && cyc == stop);
            if (reset_off >= 0 && cyc == stop) begin
                rst_ni = 1'b0;
                #1;
                checkResetOutputs("midreset");
            end else begin
                rst_ni = 1'b1;
            end
            if (done_exp && cyc == last_c + 1) checkOutput("done_busy", busy_o, 0);
            if (abort_off >= 0 && cyc == stop + 1) checkOutput("abort_ready", cmd_ready_o, 1);
            @(posedge clk_i); #1;
        end
        abort_i = 1'b0;
        rst_ni  = 1'b1;

        checkOutput("wr_count", wr_cyc.size(), n_keep);
        for (int i = 0; i < n_keep && i < wr_cyc.size(); i++) begin
            checkOutput("wr_cycle", wr_cyc[i] - t, exp_c[i] - t);
            checkOutput("wr_addr", wr_addr[i], 16 + 4 * int'(chan));
            checkOutput("wr_data", wr_data[i], exp_val[i]);
        end
        checkOutput("done_count", done_cyc.size(), done_exp ? 1 : 0);
        if (done_exp && done_cyc.size() > 0) checkOutput("done_cycle", done_cyc[0] - t, last_c + 1 - t);
        checkOutput("err_count", err_cyc.size(), legal ? 0 : 1);
        if (!legal && err_cyc.size() > 0) checkOutput("err_cycle", err_cyc[0] - t, 1);
        if (!legal) checkOutput("err_busy", busy_seen, 0);
        checkOutput("end_ready", cmd_ready_o, 1);
        if (n_keep > 0) ref_duty[chan] = exp_val[n_keep - 1];
    endtask

    initial begin
        rst_ni         = 1'b0;
        cmd_valid_i    = 1'b0;
        cmd_chan_i     = '0;
        cmd_target_i   = '0;
        cmd_step_i     = '0;
        cmd_interval_i = '0;
        abort_i        = 1'b0;
        preload_en     = 1'b0;
        preload_idx    = '0;
        preload_val    = '0;

        @(posedge clk_i); #1;
        checkResetOutputs("reset");
        for (int c = 0; c < 4; c++) preload(2'(c), 16'h0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        preload(2'd1, 16'h0);
        applyStimulus(2'd1, 16'd10, 16'd4, 16'd2, -1, -1);
        preload(2'd0, 16'h0005);
        applyStimulus(2'd0, 16'd0, 16'd3, 16'd0, -1, -1);
        preload(2'd2, 16'hFFF0);
        applyStimulus(2'd2, 16'hFFFF, 16'h0020, 16'd1, -1, -1);
        applyStimulus(2'd2, 16'h1234, 16'd0, 16'd3, -1, -1);
        preload(2'd2, 16'h0);
        applyStimulus(2'd2, 16'd100, 16'd10, 16'd5, 22, -1);
        applyStimulus(2'd3, 16'd50, 16'd5, 16'd1, -1, -1);
        preload(2'd1, 16'h0);
        applyStimulus(2'd1, 16'd200, 16'd10, 16'd4, -1, 15);
        applyStimulus(2'd1, 16'd25, 16'd10, 16'd1, -1, -1);
        applyStimulus(2'd0, 16'd0, 16'd5, 16'd2, -1, -1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ch;
            logic [15:0] tg, st, iv;
            int          diff, ab;
            ch = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) preload(ch, 16'($urandom));
            tg = 16'($urandom);
            diff = int'(tg) - ref_duty[ch];
            if (diff < 0) diff = -diff;
            case ($urandom_range(0, 3))
                0: st = 16'h0;
                1: st = 16'hFFFF;
                default: st = 16'(diff / int'($urandom_range(1, 8)) + int'($urandom_range(1, 3)));
            endcase
            iv = 16'($urandom_range(0, 3));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3 + int'(iv) + 8 * (int'(iv) + 2))) : -1;
            applyStimulus(ch, tg, st, iv, ab, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
